// File: rtl/vga_pattern_gen.sv
// Pixel source for vga_driver: four selectable RGB444 test patterns with per-frame
// animation state (frame counter, bouncing box, checker phase) and frame-aligned mode steps.
//
// mode          | meaning
// MODE_BARS     | eight vertical colour bars
// MODE_CHECKER  | 32x32 checkerboard, phase flips every 32 unpaused frames
// MODE_GRADIENT | R from column, G from row, B from frame counter
// MODE_BOX      | bouncing box, colour steps on each bounce
module vga_pattern_gen #(
  parameter int H_DISP   = 640,
  parameter int V_DISP   = 480,
  parameter int BOX_SIZE = 32,
  parameter int STEP     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  vga_xpos,
  input  logic [9:0]  vga_ypos,
  input  logic        btn_next,
  input  logic        pause,
  output logic [11:0] vga_data,
  output logic [1:0]  mode,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {
    MODE_BARS     = 2'd0,
    MODE_CHECKER  = 2'd1,
    MODE_GRADIENT = 2'd2,
    MODE_BOX      = 2'd3
  } mode_t;

  localparam logic [10:0] X_LIM  = 11'(H_DISP - BOX_SIZE);
  localparam logic [10:0] Y_LIM  = 11'(V_DISP - BOX_SIZE);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);
  localparam int          BAR_W  = H_DISP / 8;

  mode_t       mode_q, mode_n;
  logic        pending_q, pending_n;
  logic        btn_prev_q;
  logic [15:0] frame_cnt_q, frame_cnt_n;
  logic [9:0]  box_x_q, box_x_n, box_y_q, box_y_n;
  logic        dir_x_neg_q, dir_x_neg_n, dir_y_neg_q, dir_y_neg_n;
  logic [2:0]  colour_q, colour_n;
  logic        phase_q, phase_n;
  logic [11:0] pixel_q, pixel_n;

  logic        tick, btn_edge, advance, bounce_x, bounce_y;
  logic [10:0] x11, y11, bx11, by11;
  logic [2:0]  bar;
  logic        in_range, in_box;

  assign x11      = {1'b0, vga_xpos};
  assign y11      = {1'b0, vga_ypos};
  assign bx11     = {1'b0, box_x_q};
  assign by11     = {1'b0, box_y_q};
  assign tick     = (vga_xpos == 10'(H_DISP - 1)) && (vga_ypos == 10'(V_DISP - 1));
  assign btn_edge = btn_next & ~btn_prev_q;
  assign advance  = tick & ~pause;
  assign in_range = (x11 < 11'(H_DISP)) && (y11 < 11'(V_DISP));
  assign in_box   = (x11 >= bx11) && (x11 < bx11 + BOX_W) &&
                    (y11 >= by11) && (y11 < by11 + BOX_W);

  always_comb begin
    mode_n    = mode_q;
    pending_n = pending_q;
    if (tick && (pending_q || btn_edge)) begin
      mode_n    = mode_t'(mode_q + 2'd1);
      pending_n = 1'b0;
    end else if (btn_edge) begin
      pending_n = 1'b1;
    end
  end

  always_comb begin
    frame_cnt_n = frame_cnt_q;
    phase_n     = phase_q;
    if (advance) begin
      frame_cnt_n = frame_cnt_q + 16'd1;
      if (frame_cnt_n[4:0] == 5'd0) phase_n = ~phase_q;
    end
  end

  // Wall hits clamp to the wall and reverse; the clamped tick is the bounce.
  always_comb begin
    box_x_n     = box_x_q;
    dir_x_neg_n = dir_x_neg_q;
    bounce_x    = 1'b0;
    if (!dir_x_neg_q && (bx11 + STEP_W > X_LIM)) begin
      box_x_n     = 10'(X_LIM);
      dir_x_neg_n = 1'b1;
      bounce_x    = 1'b1;
    end else if (dir_x_neg_q && (bx11 < STEP_W)) begin
      box_x_n     = 10'd0;
      dir_x_neg_n = 1'b0;
      bounce_x    = 1'b1;
    end else if (dir_x_neg_q) begin
      box_x_n = 10'(bx11 - STEP_W);
    end else begin
      box_x_n = 10'(bx11 + STEP_W);
    end
  end

  always_comb begin
    box_y_n     = box_y_q;
    dir_y_neg_n = dir_y_neg_q;
    bounce_y    = 1'b0;
    if (!dir_y_neg_q && (by11 + STEP_W > Y_LIM)) begin
      box_y_n     = 10'(Y_LIM);
      dir_y_neg_n = 1'b1;
      bounce_y    = 1'b1;
    end else if (dir_y_neg_q && (by11 < STEP_W)) begin
      box_y_n     = 10'd0;
      dir_y_neg_n = 1'b0;
      bounce_y    = 1'b1;
    end else if (dir_y_neg_q) begin
      box_y_n = 10'(by11 - STEP_W);
    end else begin
      box_y_n = 10'(by11 + STEP_W);
    end
  end

  always_comb begin
    colour_n = colour_q;
    if (bounce_x || bounce_y) colour_n = (colour_q == 3'd5) ? 3'd0 : colour_q + 3'd1;
  end

  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (x11 >= 11'(k * BAR_W)) bar = 3'(k);
    end
  end

  always_comb begin
    pixel_n = 12'h000;
    if (in_range) begin
      case (mode_q)
        MODE_BARS: begin
          case (bar)
            3'd0:    pixel_n = 12'hFFF;
            3'd1:    pixel_n = 12'hFF0;
            3'd2:    pixel_n = 12'h0FF;
            3'd3:    pixel_n = 12'h0F0;
            3'd4:    pixel_n = 12'hF0F;
            3'd5:    pixel_n = 12'hF00;
            3'd6:    pixel_n = 12'h00F;
            default: pixel_n = 12'h000;
          endcase
        end
        MODE_CHECKER:  pixel_n = (vga_xpos[5] ^ vga_ypos[5] ^ phase_q) ? 12'hFFF : 12'h000;
        MODE_GRADIENT: pixel_n = {vga_xpos[9:6], vga_ypos[8:5], frame_cnt_q[7:4]};
        default: begin
          if (in_box) begin
            case (colour_q)
              3'd0:    pixel_n = 12'hF00;
              3'd1:    pixel_n = 12'h0F0;
              3'd2:    pixel_n = 12'h00F;
              3'd3:    pixel_n = 12'hFF0;
              3'd4:    pixel_n = 12'h0FF;
              default: pixel_n = 12'hF0F;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q      <= MODE_BARS;
      pending_q   <= 1'b0;
      btn_prev_q  <= 1'b0;
      frame_cnt_q <= 16'd0;
      box_x_q     <= 10'd0;
      box_y_q     <= 10'd0;
      dir_x_neg_q <= 1'b0;
      dir_y_neg_q <= 1'b0;
      colour_q    <= 3'd0;
      phase_q     <= 1'b0;
      pixel_q     <= 12'h000;
    end else begin
      mode_q      <= mode_n;
      pending_q   <= pending_n;
      btn_prev_q  <= btn_next;
      frame_cnt_q <= frame_cnt_n;
      phase_q     <= phase_n;
      pixel_q     <= pixel_n;
      if (advance) begin
        box_x_q     <= box_x_n;
        box_y_q     <= box_y_n;
        dir_x_neg_q <= dir_x_neg_n;
        dir_y_neg_q <= dir_y_neg_n;
        colour_q    <= colour_n;
      end
    end
  end

  assign vga_data  = pixel_q;
  assign mode      = mode_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: two instances (default, and a large-step variant where both
// walls are hit on the same tick) checked against a tick-level arithmetic model via a scoreboard.
module tb_vga_pattern_gen;

  localparam int H = 640;
  localparam int V = 480;
  localparam int B = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  xpos = '0, ypos = '0;
  logic        btn = 1'b0, pse = 1'b0;
  logic [11:0] data0, data1;
  logic [1:0]  mode0, mode1;
  logic [15:0] fc0, fc1;

  always #5 clk = ~clk;

  vga_pattern_gen dut0 (
    .clk(clk), .rst_n(rst_n), .vga_xpos(xpos), .vga_ypos(ypos),
    .btn_next(btn), .pause(pse), .vga_data(data0), .mode(mode0), .frame_cnt(fc0));

  vga_pattern_gen #(.STEP(320)) dut1 (
    .clk(clk), .rst_n(rst_n), .vga_xpos(xpos), .vga_ypos(ypos),
    .btn_next(btn), .pause(pse), .vga_data(data1), .mode(mode1), .frame_cnt(fc1));

  typedef struct {
    int          tag;
    logic [11:0] d;
    logic [1:0]  m;
    logic [15:0] f;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int errors = 0;
  int checks = 0;

  // Reference state, one slot per instance.
  int m_mode[2], m_fc[2], m_bx[2], m_by[2], m_dx[2], m_dy[2], m_ci[2], m_ph[2];
  bit m_pend[2], m_prev[2];
  bit cur_btn = 1'b0, cur_pause = 1'b0;

  function automatic int step_of(input int u);
    return (u == 0) ? 4 : 320;
  endfunction

  function automatic logic [11:0] bar_col(input int i);
    case (i)
      0: return 12'hFFF; 1: return 12'hFF0; 2: return 12'h0FF; 3: return 12'h0F0;
      4: return 12'hF0F; 5: return 12'hF00; 6: return 12'h00F; default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] pal_col(input int i);
    case (i)
      0: return 12'hF00; 1: return 12'h0F0; 2: return 12'h00F;
      3: return 12'hFF0; 4: return 12'h0FF; default: return 12'hF0F;
    endcase
  endfunction

  function automatic logic [11:0] model_pixel(input int u, input int x, input int y);
    if (x >= H || y >= V) return 12'h000;
    case (m_mode[u])
      0: return bar_col(x / (H / 8));
      1: return ((((x / 32) % 2) ^ ((y / 32) % 2) ^ m_ph[u]) != 0) ? 12'hFFF : 12'h000;
      2: return 12'(((x / 64) % 16) * 256 + ((y / 32) % 16) * 16 + ((m_fc[u] / 16) % 16));
      default:
        return (x >= m_bx[u] && x < m_bx[u] + B && y >= m_by[u] && y < m_by[u] + B)
               ? pal_col(m_ci[u]) : 12'h000;
    endcase
  endfunction

  task automatic axis(input int pos, input int dir, input int lim, input int s,
                      output int npos, output int ndir, output bit bnc);
    npos = pos; ndir = dir; bnc = 1'b0;
    if (dir > 0 && pos + s > lim) begin
      npos = lim; ndir = -1; bnc = 1'b1;
    end else if (dir < 0 && pos < s) begin
      npos = 0; ndir = 1; bnc = 1'b1;
    end else begin
      npos = pos + dir * s;
    end
  endtask

  task automatic model_cycle(input int u, input int x, input int y, input bit b,
                             input bit p, input bit r, output logic [11:0] d);
    bit edge_seen, tick, bx, by;
    int nx, ny, ndx, ndy;
    if (!r) begin
      d = 12'h000;
      m_mode[u] = 0; m_fc[u] = 0; m_bx[u] = 0; m_by[u] = 0; m_dx[u] = 1; m_dy[u] = 1;
      m_ci[u] = 0; m_ph[u] = 0; m_pend[u] = 1'b0; m_prev[u] = 1'b0;
      return;
    end
    d = model_pixel(u, x, y);
    edge_seen = b && !m_prev[u];
    m_prev[u] = b;
    tick = (x == H - 1) && (y == V - 1);
    if (tick && (m_pend[u] || edge_seen)) begin
      m_mode[u] = (m_mode[u] + 1) % 4;
      m_pend[u] = 1'b0;
    end else if (edge_seen) begin
      m_pend[u] = 1'b1;
    end
    if (tick && !p) begin
      m_fc[u] = (m_fc[u] + 1) % 65536;
      if (m_fc[u] % 32 == 0) m_ph[u] = 1 - m_ph[u];
      axis(m_bx[u], m_dx[u], H - B, step_of(u), nx, ndx, bx);
      axis(m_by[u], m_dy[u], V - B, step_of(u), ny, ndy, by);
      m_bx[u] = nx; m_dx[u] = ndx; m_by[u] = ny; m_dy[u] = ndy;
      if (bx || by) m_ci[u] = (m_ci[u] + 1) % 6;
    end
  endtask

  task automatic cyc(input int x, input int y, input bit b, input bit p, input bit r,
                     input int tag);
    exp_t e;
    @(negedge clk);
    xpos = 10'(x); ypos = 10'(y); btn = b; pse = p; rst_n = r;
    for (int u = 0; u < 2; u++) begin
      model_cycle(u, x, y, b, p, r, e.d);
      e.tag = tag; e.m = 2'(m_mode[u]); e.f = 16'(m_fc[u]);
      if (u == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic px(input int x, input int y, input int tag);
    cyc(x, y, cur_btn, cur_pause, 1'b1, tag);
  endtask

  task automatic tick_now(input int tag);
    px(H - 1, V - 1, tag);
  endtask

  task automatic rnd_px(input int tag);
    int x, y;
    x = $urandom_range(0, 1023);
    y = $urandom_range(0, 520);
    if (x == H - 1 && y == V - 1) y = 0;
    px(x, y, tag);
  endtask

  task automatic press(input int tag);
    cur_btn = 1'b1; px(0, 0, tag);
    cur_btn = 1'b0; px(0, 0, tag);
  endtask

  task automatic probe_boxes(input int tag);
    for (int u = 0; u < 2; u++) begin
      px(m_bx[u], m_by[u], tag);
      px(m_bx[u] + B - 1, m_by[u], tag);
      px(m_bx[u], m_by[u] + B - 1, tag);
      px(m_bx[u] + B, m_by[u], tag);
      if (m_bx[u] > 0) px(m_bx[u] - 1, m_by[u], tag);
    end
    rnd_px(tag);
  endtask

  task automatic compare(input int u, input exp_t e, input logic [11:0] d,
                         input logic [1:0] m, input logic [15:0] f);
    checks++;
    if (d !== e.d) begin
      errors++;
      $display("FAIL u%0d tag%0d vga_data got %h want %h", u, e.tag, d, e.d);
    end
    checks++;
    if (m !== e.m) begin
      errors++;
      $display("FAIL u%0d tag%0d mode got %0d want %0d", u, e.tag, m, e.m);
    end
    checks++;
    if (f !== e.f) begin
      errors++;
      $display("FAIL u%0d tag%0d frame_cnt got %0d want %0d", u, e.tag, f, e.f);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin e = q0.pop_front(); compare(0, e, data0, mode0, fc0); end
      if (q1.size() > 0) begin e = q1.pop_front(); compare(1, e, data1, mode1, fc1); end
    end
  end

  initial begin
    int wait_cnt;
    for (int i = 0; i < 3; i++) cyc(0, 0, 1'b0, 1'b0, 1'b0, 1);

    px(100, 10, 2); px(639, 0, 2); px(700, 0, 2); px(0, 0, 2); px(80, 5, 2); px(79, 5, 2);
    for (int i = 0; i < 20; i++) rnd_px(2);

    press(3); press(3); press(3); press(3);
    for (int i = 0; i < 5; i++) rnd_px(3);
    tick_now(3);
    px(0, 0, 3); px(32, 0, 3);
    tick_now(3);
    px(0, 0, 3);

    while (m_fc[0] < 35) begin
      for (int i = 0; i < 4; i++) rnd_px(4);
      tick_now(4);
    end
    press(5); tick_now(5);
    for (int i = 0; i < 6; i++) rnd_px(5);
    tick_now(5);
    for (int i = 0; i < 6; i++) rnd_px(5);
    cyc(320, 240, cur_btn, cur_pause, 1'b0, 6);
    px(0, 0, 6); px(100, 10, 6);

    for (int i = 0; i < 2; i++) cyc(0, 0, 1'b0, 1'b0, 1'b0, 7);
    cur_pause = 1'b1;
    for (int i = 0; i < 3; i++) begin press(7); tick_now(7); end
    cur_pause = 1'b0;
    probe_boxes(7);
    for (int t = 1; t <= 160; t++) begin
      tick_now(7);
      probe_boxes(7);
    end

    cur_pause = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      if (t == 8) press(8);
      tick_now(8);
      probe_boxes(8);
    end
    cur_pause = 1'b0;

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) cur_btn = ~cur_btn;
      if ($urandom_range(0, 99) == 0) cur_pause = ~cur_pause;
      if ($urandom_range(0, 499) == 0) cyc(0, 0, cur_btn, cur_pause, 1'b0, 9);
      else if ($urandom_range(0, 29) == 0) tick_now(9);
      else rnd_px(9);
    end

    wait_cnt = 0;
    while ((q0.size() > 0 || q1.size() > 0) && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    checks++;
    if (q0.size() > 0 || q1.size() > 0) begin
      errors++;
      $display("FAIL drain queue left %0d/%0d want 0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
